// File: rtl/uart_receiver_if.sv
// Consumer-side bundle of the UART receiver: received byte, ready/ack
// handshake, error flags, busy indication and an FSM state view.
//
// Handshake: data_ready is high while data_out holds an unread byte. The
// consumer raises rd_ack for a clk edge to take the byte. That edge clears
// data_ready and overrun. rd_ack has no effect while data_ready is low. If a
// new byte lands on the same edge as rd_ack, the new byte is loaded and
// data_ready stays high.
interface uart_receiver_if;
  logic [7:0] data_out;
  logic       data_ready;
  logic       rd_ack;
  logic       frame_err;
  logic       overrun;
  logic       busy;
  logic [1:0] fsm_state;

  // Receiver side drives the byte and status and listens to the ack
  modport master (
    output data_out, data_ready, frame_err, overrun, busy, fsm_state,
    input  rd_ack
  );

  // Consumer side reads the byte and status and drives the ack
  modport slave (
    input  data_out, data_ready, frame_err, overrun, busy, fsm_state,
    output rd_ack
  );
endinterface

// File: rtl/uart_receiver.sv
// RS232 8N1 receiver. The block synchronises rx and oversamples each bit 16x.
// It confirms the start bit at its mid-point and then samples every data bit
// and the stop bit at their mid-points. Completed bytes go into a one-deep
// holding register read through a ready/ack handshake. The block reports
// framing errors as a one-clk pulse and overruns as a sticky flag.
module uart_receiver #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  uart_receiver_if.master  bus
);

  localparam int TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW       = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SAMP_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state, state_next;
  logic          sync1, rx_s, prev_rx;
  logic          start_edge;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [SW-1:0] samp;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [7:0]    data_out_q;
  logic          data_ready_q;
  logic          frame_err_q;
  logic          overrun_q;
  logic          busy_q;

  // FSM strobes to the datapath
  logic samp_clr, samp_inc, bit_clr, bit_inc, shift_en;
  logic load, ovr_set, ferr_set;

  assign start_edge = prev_rx & ~rx_s;
  assign tick       = (tick_cnt == TICK_LAST);

  // Two-flop synchroniser plus edge-detect history, all resetting to idle-high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      prev_rx <= 1'b1;
    end else begin
      sync1   <= rx;
      rx_s    <= sync1;
      prev_rx <= rx_s;
    end
  end

  // Tick divider is held at 0 while idle so it stays phase-locked to the start edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (state == IDLE || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state and datapath strobes
  always_comb begin
    state_next = state;
    samp_clr   = 1'b0;
    samp_inc   = 1'b0;
    bit_clr    = 1'b0;
    bit_inc    = 1'b0;
    shift_en   = 1'b0;
    load       = 1'b0;
    ovr_set    = 1'b0;
    ferr_set   = 1'b0;
    case (state)
      IDLE: begin
        // Only a 1->0 transition starts a frame, so a held-low break cannot retrigger
        if (start_edge) begin
          state_next = START;
          samp_clr   = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (samp == SAMP_MID) begin
            if (rx_s) begin
              state_next = IDLE;
            end else begin
              state_next = DATA;
              samp_clr   = 1'b1;
              bit_clr    = 1'b1;
            end
          end else begin
            samp_inc = 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (samp == SAMP_LAST) begin
            shift_en = 1'b1;
            samp_clr = 1'b1;
            if (bit_idx == 3'd7) begin
              state_next = STOP;
            end else begin
              bit_inc = 1'b1;
            end
          end else begin
            samp_inc = 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (samp == SAMP_LAST) begin
            // Leave at mid stop bit so a following start edge is not missed
            state_next = IDLE;
            samp_clr   = 1'b1;
            if (rx_s) begin
              if (!data_ready_q || bus.rd_ack) begin
                load = 1'b1;
              end else begin
                ovr_set = 1'b1;
              end
            end else begin
              ferr_set = 1'b1;
            end
          end else begin
            samp_inc = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Sample counter, bit index and LSB-first shift register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (samp_clr) begin
        samp <= '0;
      end else if (samp_inc) begin
        samp <= samp + 1'b1;
      end
      if (bit_clr) begin
        bit_idx <= '0;
      end else if (bit_inc) begin
        bit_idx <= bit_idx + 1'b1;
      end
      if (shift_en) begin
        shreg <= {rx_s, shreg[7:1]};
      end
    end
  end

  // Holding register, handshake and error flags; a load overrides an ack on the same edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out_q   <= '0;
      data_ready_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      frame_err_q <= ferr_set;
      busy_q      <= (state_next != IDLE);
      if (bus.rd_ack && data_ready_q) begin
        data_ready_q <= 1'b0;
        overrun_q    <= 1'b0;
      end
      if (load) begin
        data_out_q   <= shreg;
        data_ready_q <= 1'b1;
      end
      if (ovr_set) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_ready = data_ready_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = busy_q;
  assign bus.fsm_state  = state;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: the line is driven at 868 clk per bit,
// like the board transmitter. Each scenario task checks its own results.
module tb_uart_receiver;

  localparam int BIT_CLK     = 868;
  // Posedges from the first posedge after the start-bit drive to the load edge:
  // 2 for the synchroniser/edge detect, then 152 ticks of 54 clk each.
  localparam int LOAD_OFFSET = 2 + 152 * 54;

  logic clk;
  logic rst;
  logic rx;
  int   tests;
  int   fails;

  // Monitor counters, sampled on the falling edge
  int   ferr_cycles;
  int   ferr_pulses;
  int   busy_rises;
  logic ferr_prev;
  logic busy_prev;

  logic [7:0] exp_q[$];

  uart_receiver_if bus();

  uart_receiver dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .bus (bus)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #(10 * 150000);
    $display("FAIL watchdog: simulation did not finish within 150000 clk");
    $fatal(1, "watchdog");
  end

  // Pulse and edge monitor
  initial begin
    ferr_cycles = 0;
    ferr_pulses = 0;
    busy_rises  = 0;
    ferr_prev   = 1'b0;
    busy_prev   = 1'b0;
  end

  always @(negedge clk) begin
    ferr_prev <= bus.frame_err;
    busy_prev <= bus.busy;
    if (bus.frame_err === 1'b1) ferr_cycles <= ferr_cycles + 1;
    if (bus.frame_err === 1'b1 && ferr_prev !== 1'b1) ferr_pulses <= ferr_pulses + 1;
    if (bus.busy === 1'b1 && busy_prev !== 1'b1) busy_rises <= busy_rises + 1;
  end

  // Driver: one 8N1 frame, LSB first, with a selectable stop-bit level
  task automatic send_byte(input logic [7:0] d, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    rx = stop;
    repeat (BIT_CLK) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    bus.rd_ack = 1'b1;
    @(negedge clk);
    bus.rd_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] obs;
    rst = 1'b0;
    rx  = 1'b1;
    bus.rd_ack = 1'b0;
    #1;
    obs = {bus.data_out, bus.data_ready, bus.frame_err, bus.overrun, bus.busy};
    tests++;
    if (obs !== 12'h000) begin
      $display("FAIL reset_outputs: got %h want 000", obs);
      fails++;
    end
    tests++;
    if (bus.fsm_state !== 2'd0) begin
      $display("FAIL reset_state: got %0d want 0", bus.fsm_state);
      fails++;
    end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  // T1: reset in the middle of a frame, then a clean 0xA5
  task automatic test_reset_mid_frame();
    int   glitches;
    int   f0;
    glitches = 0;
    @(negedge clk);
    rx = 1'b0;
    repeat (2000) @(negedge clk);
    tests++;
    if (bus.busy !== 1'b1) begin
      $display("FAIL t1_busy_mid_frame: got %b want 1", bus.busy);
      fails++;
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({bus.data_out, bus.data_ready, bus.frame_err, bus.overrun, bus.busy} !== 12'h000)
        glitches++;
    end
    tests++;
    if (glitches != 0) begin
      $display("FAIL t1_reset_hold: got %0d nonzero cycles want 0", glitches);
      fails++;
    end
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    tests++;
    if (bus.busy !== 1'b0) begin
      $display("FAIL t1_busy_after_reset: got %b want 0", bus.busy);
      fails++;
    end
    f0 = ferr_cycles;
    send_byte(8'hA5, 1'b1);
    tests++;
    if (bus.data_out !== 8'hA5) begin
      $display("FAIL t1_data: got %h want a5", bus.data_out);
      fails++;
    end
    tests++;
    if (bus.data_ready !== 1'b1) begin
      $display("FAIL t1_ready: got %b want 1", bus.data_ready);
      fails++;
    end
    tests++;
    if (ferr_cycles - f0 != 0) begin
      $display("FAIL t1_frame_err: got %0d cycles want 0", ferr_cycles - f0);
      fails++;
    end
    pulse_ack();
    tests++;
    if (bus.data_ready !== 1'b0) begin
      $display("FAIL t1_ack_clears: got %b want 0", bus.data_ready);
      fails++;
    end
  endtask

  // T2: 200-clk low glitch is rejected at the start-bit mid-point
  task automatic test_false_start();
    int b0;
    b0 = busy_rises;
    @(negedge clk);
    rx = 1'b0;
    repeat (200) @(negedge clk);
    rx = 1'b1;
    repeat (1000) @(negedge clk);
    tests++;
    if (busy_rises - b0 != 1) begin
      $display("FAIL t2_busy_pulse: got %0d rises want 1", busy_rises - b0);
      fails++;
    end
    tests++;
    if (bus.busy !== 1'b0) begin
      $display("FAIL t2_busy_end: got %b want 0", bus.busy);
      fails++;
    end
    tests++;
    if (bus.data_ready !== 1'b0 || bus.data_out !== 8'hA5) begin
      $display("FAIL t2_no_data: got ready %b data %h want ready 0 data a5",
               bus.data_ready, bus.data_out);
      fails++;
    end
  endtask

  // T3: stop bit driven low
  task automatic test_frame_err();
    int c0;
    int p0;
    c0 = ferr_cycles;
    p0 = ferr_pulses;
    send_byte(8'h3C, 1'b0);
    repeat (10) @(negedge clk);
    tests++;
    if (ferr_pulses - p0 != 1) begin
      $display("FAIL t3_ferr_pulses: got %0d want 1", ferr_pulses - p0);
      fails++;
    end
    tests++;
    if (ferr_cycles - c0 != 1) begin
      $display("FAIL t3_ferr_width: got %0d clk want 1", ferr_cycles - c0);
      fails++;
    end
    tests++;
    if (bus.data_ready !== 1'b0) begin
      $display("FAIL t3_ready: got %b want 0", bus.data_ready);
      fails++;
    end
    tests++;
    if (bus.data_out !== 8'hA5) begin
      $display("FAIL t3_data_kept: got %h want a5", bus.data_out);
      fails++;
    end
  endtask

  // T4: second byte arrives while the first is unread
  task automatic test_overrun();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    tests++;
    if (bus.data_out !== 8'h11) begin
      $display("FAIL t4_data_kept: got %h want 11", bus.data_out);
      fails++;
    end
    tests++;
    if (bus.data_ready !== 1'b1 || bus.overrun !== 1'b1) begin
      $display("FAIL t4_overrun: got ready %b overrun %b want 1 1",
               bus.data_ready, bus.overrun);
      fails++;
    end
    pulse_ack();
    tests++;
    if (bus.data_ready !== 1'b0) begin
      $display("FAIL t4_ack_ready: got %b want 0", bus.data_ready);
      fails++;
    end
    tests++;
    if (bus.overrun !== 1'b0) begin
      $display("FAIL t4_ack_overrun: got %b want 0", bus.overrun);
      fails++;
    end
    pulse_ack();
    tests++;
    if (bus.data_ready !== 1'b0 || bus.data_out !== 8'h11 || bus.overrun !== 1'b0) begin
      $display("FAIL t4_idle_ack: got ready %b data %h overrun %b want 0 11 0",
               bus.data_ready, bus.data_out, bus.overrun);
      fails++;
    end
  endtask

  // T5: rd_ack on the very edge that loads the next byte
  task automatic test_ack_on_load();
    send_byte(8'h11, 1'b1);
    tests++;
    if (bus.data_ready !== 1'b1 || bus.data_out !== 8'h11) begin
      $display("FAIL t5_first: got ready %b data %h want 1 11", bus.data_ready, bus.data_out);
      fails++;
    end
    fork
      send_byte(8'h22, 1'b1);
      begin
        @(negedge clk);
        repeat (LOAD_OFFSET) @(posedge clk);
        @(negedge clk);
        bus.rd_ack = 1'b1;
        @(negedge clk);
        bus.rd_ack = 1'b0;
      end
    join
    tests++;
    if (bus.data_out !== 8'h22) begin
      $display("FAIL t5_data: got %h want 22", bus.data_out);
      fails++;
    end
    tests++;
    if (bus.data_ready !== 1'b1) begin
      $display("FAIL t5_ready: got %b want 1", bus.data_ready);
      fails++;
    end
    tests++;
    if (bus.overrun !== 1'b0) begin
      $display("FAIL t5_overrun: got %b want 0", bus.overrun);
      fails++;
    end
    pulse_ack();
  endtask

  // T6: three back-to-back frames, each acked once it is ready
  task automatic test_back_to_back();
    int c0;
    c0 = ferr_cycles;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h55);
    fork
      begin
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h55, 1'b1);
      end
      begin
        for (int k = 0; k < 3; k++) begin
          int         n;
          logic [7:0] exp;
          n = 0;
          while (bus.data_ready !== 1'b1 && n < 12000) begin
            @(negedge clk);
            n++;
          end
          exp = exp_q.pop_front();
          tests++;
          if (n >= 12000) begin
            $display("FAIL t6_timeout_%0d: got no data_ready want byte %h", k, exp);
            fails++;
          end else if (bus.data_out !== exp) begin
            $display("FAIL t6_byte_%0d: got %h want %h", k, bus.data_out, exp);
            fails++;
          end
          bus.rd_ack = 1'b1;
          @(negedge clk);
          bus.rd_ack = 1'b0;
        end
      end
    join
    repeat (10) @(negedge clk);
    tests++;
    if (ferr_cycles - c0 != 0) begin
      $display("FAIL t6_frame_err: got %0d cycles want 0", ferr_cycles - c0);
      fails++;
    end
    tests++;
    if (bus.overrun !== 1'b0 || bus.data_ready !== 1'b0) begin
      $display("FAIL t6_flags: got overrun %b ready %b want 0 0", bus.overrun, bus.data_ready);
      fails++;
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_reset_mid_frame();
    test_false_start();
    test_frame_err();
    test_overrun();
    test_ack_on_load();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
